// File: rtl/pipelined_add_sub_n_if.sv
// Handshake and data bundle for pipelined_add_sub_n: operand beat in, result beat out.
// The slave modport is the adder's view; master is the producer/consumer side.
interface pipelined_add_sub_n_if #(
  parameter int unsigned WIDTH = 24
);
  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, op_sub, cin, a, b, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, op_sub, cin, a, b, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_add_sub_n.sv
// Segment-pipelined WIDTH-bit adder/subtractor, one SEG-bit segment per stage, valid/ready.
// Define ADD_SAT_EN to build unsigned saturation into the final stage.
module pipelined_add_sub_n #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned SEG   = 8
) (
  input logic                  clk,
  input logic                  rst,
  pipelined_add_sub_n_if.slave bus
);
  localparam int unsigned NSEG = WIDTH / SEG;

  if ((WIDTH % SEG) != 0) begin : g_bad_param
    $error("pipelined_add_sub_n: WIDTH must be a multiple of SEG");
  end

  logic adv;

  // Per-stage registers: operands travel whole (upper segments still to be added),
  // res_q accumulates finished low segments, cy_q is the carry into the next segment.
  logic [NSEG-1:0]  vld_q;
  logic [NSEG-1:0]  cy_q;
  logic [WIDTH-1:0] opa_q [NSEG];
  logic [WIDTH-1:0] opb_q [NSEG];
  logic [WIDTH-1:0] res_q [NSEG];
  logic             ovf_q;

  // Stage inputs: stage 0 is fed from the bus, stage k from stage k-1.
  logic [NSEG-1:0]  v_src;
  logic [NSEG-1:0]  c_src;
  logic [WIDTH-1:0] a_src [NSEG];
  logic [WIDTH-1:0] b_src [NSEG];
  logic [WIDTH-1:0] r_src [NSEG];

  logic [SEG:0]     seg_sum [NSEG];
  logic [NSEG-1:0]  cy_d;
  logic [WIDTH-1:0] res_d [NSEG];
  logic [WIDTH-1:0] sum_d;
  logic             ovf_d;

`ifdef ADD_SAT_EN
  logic [NSEG-1:0] sub_q;
  logic [NSEG-1:0] sub_src;
`endif

  // The whole pipeline moves only when the output slot is free or being drained.
  assign adv           = bus.out_ready | ~vld_q[NSEG-1];
  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_q[NSEG-1];
  assign bus.sum       = res_q[NSEG-1];
  assign bus.cout      = cy_q[NSEG-1];
  assign bus.ovf       = ovf_q;

  always_comb begin
    v_src    = '0;
    c_src    = '0;
    v_src[0] = bus.in_valid;
    // Subtraction is a + ~b + 1: the +1 rides in as the stage-0 carry.
    c_src[0] = bus.op_sub | bus.cin;
    a_src[0] = bus.a;
    b_src[0] = bus.op_sub ? ~bus.b : bus.b;
    r_src[0] = '0;
`ifdef ADD_SAT_EN
    sub_src    = '0;
    sub_src[0] = bus.op_sub;
`endif
    for (int k = 1; k < NSEG; k++) begin
      v_src[k] = vld_q[k-1];
      c_src[k] = cy_q[k-1];
      a_src[k] = opa_q[k-1];
      b_src[k] = opb_q[k-1];
      r_src[k] = res_q[k-1];
`ifdef ADD_SAT_EN
      sub_src[k] = sub_q[k-1];
`endif
    end
  end

  always_comb begin
    cy_d = '0;
    for (int k = 0; k < NSEG; k++) begin
      seg_sum[k] = {1'b0, a_src[k][k*SEG +: SEG]} + {1'b0, b_src[k][k*SEG +: SEG]}
                 + {{SEG{1'b0}}, c_src[k]};
      res_d[k]              = r_src[k];
      res_d[k][k*SEG +: SEG] = seg_sum[k][SEG-1:0];
      cy_d[k]               = seg_sum[k][SEG];
    end
  end

  // Final stage: signed overflow from the effective operand signs, optional clamp.
  always_comb begin
    sum_d = res_d[NSEG-1];
    ovf_d = (a_src[NSEG-1][WIDTH-1] == b_src[NSEG-1][WIDTH-1]) &
            (res_d[NSEG-1][WIDTH-1] != a_src[NSEG-1][WIDTH-1]);
`ifdef ADD_SAT_EN
    if (sub_src[NSEG-1] ? ~cy_d[NSEG-1] : cy_d[NSEG-1]) begin
      sum_d = sub_src[NSEG-1] ? '0 : '1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      cy_q  <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < NSEG; k++) begin
        opa_q[k] <= '0;
        opb_q[k] <= '0;
        res_q[k] <= '0;
      end
`ifdef ADD_SAT_EN
      sub_q <= '0;
`endif
    end else if (adv) begin
      vld_q <= v_src;
      // Data registers load only for valid beats so outputs hold across bubbles.
      for (int k = 0; k < NSEG; k++) begin
        if (v_src[k]) begin
          opa_q[k] <= a_src[k];
          opb_q[k] <= b_src[k];
          cy_q[k]  <= cy_d[k];
          res_q[k] <= (k == NSEG - 1) ? sum_d : res_d[k];
`ifdef ADD_SAT_EN
          sub_q[k] <= sub_src[k];
`endif
        end
      end
      if (v_src[NSEG-1]) begin
        ovf_q <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_add_sub_n.sv
// Self-checking bench for pipelined_add_sub_n (WIDTH=24, SEG=8, latency 3).
// Reference results come from plain integer arithmetic on the operands.
module tb_pipelined_add_sub_n;
  localparam int unsigned W = 24;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  pipelined_add_sub_n_if #(.WIDTH(W)) bus ();

  pipelined_add_sub_n #(
    .WIDTH(W),
    .SEG  (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // Returns {sum, cout, ovf}.
  function automatic logic [W+1:0] ref_calc(logic [W-1:0] a, logic [W-1:0] b, logic s, logic c);
    longint ua, ub, sa, sb, t, st;
    logic [W-1:0] r;
    logic co, ov;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (s) begin
      t  = ua - ub;
      co = (ua >= ub);
      st = sa - sb;
    end else begin
      t  = ua + ub + longint'(c);
      co = (t >= (longint'(1) << W));
      st = sa + sb + longint'(c);
    end
    r  = t[W-1:0];
    ov = (st > 64'sd8388607) || (st < -64'sd8388608);
`ifdef ADD_SAT_EN
    if (!s && co) r = '1;
    else if (s && !co) r = '0;
`endif
    return {r, co, ov};
  endfunction

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 24'h000000;
      1:       return 24'hFFFFFF;
      2:       return 24'h7FFFFF;
      3:       return 24'h800000;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic drive_beat(logic [W-1:0] a, logic [W-1:0] b, logic s, logic c);
    bus.a = a; bus.b = b; bus.op_sub = s; bus.cin = c; bus.in_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.op_sub = 1'b0; bus.cin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.out_valid, bus.sum, bus.cout, bus.ovf} !== '0) begin
        n_bad++;
        $display("FAIL reset_state[%0d]: got vld=%b sum=%h cout=%b ovf=%b want all 0",
                 i, bus.out_valid, bus.sum, bus.cout, bus.ovf);
      end
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_in_ready[%0d]: got %b want 1", i, bus.in_ready);
      end
      @(posedge clk); #1;
    end
  endtask

  // One isolated beat with out_ready=1: checks acceptance, latency and result.
  task automatic run_one(string nm, logic [W-1:0] a, logic [W-1:0] b, logic s, logic c);
    logic [W+1:0] e;
    int lat;
    e = ref_calc(a, b, s, c);
    bus.out_ready = 1'b1;
    drive_beat(a, b, s, c);
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_accept: got in_ready=%b want 1", nm, bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) lat = i;
    end
    n_cmp++;
    if (lat != 3) begin
      n_bad++;
      $display("FAIL %s_latency: got %0d want 3", nm, lat);
    end
    n_cmp++;
    if ({bus.sum, bus.cout, bus.ovf} !== e) begin
      n_bad++;
      $display("FAIL %s_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
               nm, bus.sum, bus.cout, bus.ovf, e[W+1:2], e[1], e[0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_boundaries();
    run_one("add_seg_carry", 24'h00FFFF, 24'h000001, 1'b0, 1'b0);
    run_one("sub_zero_minus_one", 24'h000000, 24'h000001, 1'b1, 1'b0);
    run_one("add_wrap", 24'hFFFFFF, 24'h000001, 1'b0, 1'b0);
    run_one("add_pos_ovf", 24'h7FFFFF, 24'h000001, 1'b0, 1'b0);
    run_one("sub_neg_ovf", 24'h800000, 24'h000001, 1'b1, 1'b0);
    run_one("add_cin", 24'h0000FF, 24'h000000, 1'b0, 1'b1);
    run_one("sub_ignores_cin", 24'h000010, 24'h000003, 1'b1, 1'b1);
  endtask

  // Consecutive beats with no stalls must emerge on consecutive cycles.
  task automatic test_back_to_back();
    logic [W+1:0] exp_v [8];
    int got;
    bus.out_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) begin
        logic [W-1:0] a, b;
        logic s, c;
        a = rand_op(); b = rand_op(); s = i[0]; c = 1'($urandom);
        exp_v[i] = ref_calc(a, b, s, c);
        drive_beat(a, b, s, c);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (i >= 3 && i < 11) begin
        n_cmp++;
        if (bus.out_valid !== 1'b1 || {bus.sum, bus.cout, bus.ovf} !== exp_v[i-3]) begin
          n_bad++;
          $display("FAIL b2b[%0d]: got vld=%b {sum,cout,ovf}=%h want vld=1 %h",
                   i - 3, bus.out_valid, {bus.sum, bus.cout, bus.ovf}, exp_v[i-3]);
        end else begin
          got++;
        end
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (got != 8) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d want 8", got);
    end
  endtask

  // Random beats and random backpressure against an in-order scoreboard.
  task automatic test_stream();
    localparam int NBEATS = 30;
    logic [W+1:0] q[$];
    logic [W+1:0] held;
    logic [W+1:0] e;
    bit holding;
    int sent, rcvd;
    sent = 0; rcvd = 0; holding = 1'b0; held = '0;
    for (int cyc = 0; cyc < 2000 && rcvd < NBEATS; cyc++) begin
      if (sent < NBEATS && $urandom_range(0, 3) != 0) begin
        drive_beat(rand_op(), rand_op(), 1'($urandom), 1'($urandom));
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (holding) begin
        n_cmp++;
        if (bus.out_valid !== 1'b1 || {bus.sum, bus.cout, bus.ovf} !== held) begin
          n_bad++;
          $display("FAIL stall_stable: got vld=%b %h want vld=1 %h",
                   bus.out_valid, {bus.sum, bus.cout, bus.ovf}, held);
        end
      end
      if (bus.in_valid && bus.in_ready === 1'b1) begin
        q.push_back(ref_calc(bus.a, bus.b, bus.op_sub, bus.cin));
        sent++;
      end
      holding = 1'b0;
      if (bus.out_valid === 1'b1) begin
        if (bus.out_ready) begin
          n_cmp++;
          if (q.size() == 0) begin
            n_bad++;
            $display("FAIL stream_extra: got unexpected %h want no beat",
                     {bus.sum, bus.cout, bus.ovf});
          end else begin
            e = q.pop_front();
            if ({bus.sum, bus.cout, bus.ovf} !== e) begin
              n_bad++;
              $display("FAIL stream[%0d]: got %h want %h", rcvd, {bus.sum, bus.cout, bus.ovf}, e);
            end
          end
          rcvd++;
        end else begin
          holding = 1'b1;
          held    = {bus.sum, bus.cout, bus.ovf};
        end
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    n_cmp++;
    if (rcvd != NBEATS || q.size() != 0) begin
      n_bad++;
      $display("FAIL stream_count: got rcvd=%0d pending=%0d want %0d and 0",
               rcvd, q.size(), NBEATS);
    end
  endtask

  task automatic test_reset_inflight();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_beat(24'h123456 + W'(i), 24'h010101, 1'b0, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL inflight_accept[%0d]: got in_ready=%b want 1", i, bus.in_ready);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL inflight_stalled: got vld=%b rdy=%b want vld=1 rdy=0",
               bus.out_valid, bus.in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.sum !== '0) begin
        n_bad++;
        $display("FAIL inflight_flush[%0d]: got vld=%b sum=%h want vld=0 sum=000000",
                 i, bus.out_valid, bus.sum);
      end
      @(posedge clk); #1;
    end
    run_one("after_reset", 24'h00ABCD, 24'h001111, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_boundaries();
    test_back_to_back();
    test_stream();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
